matmul_apb_monitor: RTL and testbench
=====================================

Name: matmul_apb_monitor

Overview:
- Synthesizable, parametrised APB protocol monitor for the matmul accelerator slave port; the hardware successor to the team's SVA-only functional checker.
- Passively tracks every APB transfer with a phase FSM and flags protocol violations as sticky bits plus a one-cycle pulse.
- Counts completed reads, writes and error responses; can be instantiated in silicon for debug or bound in the bench.

Parameters:
- DATA_WIDTH, 16, matrix element width (pass-through, sizes MAX_DIM)
- BUS_WIDTH, 64, pwdata/prdata width
- ADDR_WIDTH, 16, paddr width
- SP_NTARGETS, 4, scratchpad targets (pass-through, unused in logic)
- TIMEOUT_CYCLES, 16, max ACCESS cycles without completion, >=1
- CNT_WIDTH, 16, width of each event counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB direction, 1 = write
- paddr  in  ADDR_WIDTH  APB address
- pwdata  in  BUS_WIDTH  APB write data
- prdata  in  BUS_WIDTH  APB read data (monitored only)
- pready  in  1  slave ready
- pslverr  in  1  slave error
- busy  in  1  accelerator busy flag
- clr  in  1  synchronous clear of sticky flags and counters
- viol  out  6  sticky violation flags, index per package constants
- viol_pulse  out  1  high for one cycle when any violation is detected
- wr_cnt  out  CNT_WIDTH  completed writes
- rd_cnt  out  CNT_WIDTH  completed reads
- err_cnt  out  CNT_WIDTH  completions with pslverr
- state  out  2  current FSM state, for debug

Behaviour:
- Reset (rst low, async): all outputs 0, FSM IDLE, captured fields and timeout counter 0.
- Completion = ACCESS state and (pready | pslverr) sampled at posedge.
- FSM IDLE: psel & ~penable -> SETUP, capture paddr/pwrite/pwdata. psel & penable -> PHASE violation, capture, go ACCESS.
- FSM SETUP: psel & penable -> ACCESS. Any other input -> PHASE violation, go IDLE.
- FSM ACCESS: on completion, update counters. Next state is SETUP if psel & ~penable that cycle (back-to-back transfer, recapture fields), else IDLE. Without completion, stay in ACCESS.
- ACCESS with psel low before completion -> PHASE violation, go IDLE.
- Violation bits:
  - 0 PHASE: illegal phase sequence, as above.
  - 1 UNSTABLE: in ACCESS, paddr, pwrite, or pwdata (writes only) differ from the captured value.
  - 2 TIMEOUT: the timeout counter increments each ACCESS cycle without completion and flags when it reaches TIMEOUT_CYCLES. It then saturates, so there is one flag per transfer. It clears on leaving ACCESS.
  - 3 PREADY_STUCK: pready high on two consecutive cycles.
  - 4 BUSY_MISS: a write to paddr==0 with pwdata[0]==1 completes without pslverr, and busy is low on the next cycle.
  - 5 ERR_READY: pslverr and pready high in the same cycle.
- Latency: a violation detected at edge N is reflected in viol and viol_pulse after edge N, i.e. both are registered. Several violations in one cycle set all their bits, with a single pulse.
- Counters: wr_cnt or rd_cnt increments on every completion, selected by captured pwrite. err_cnt additionally increments when pslverr is high. All counters saturate at all-ones with no wrap.
- clr: zeroes viol and all counters. A violation or completion in the same cycle is still recorded, so the sticky bit is set or the counter reads 1. clr does not affect FSM or transfer tracking.
- Reset mid-transfer: everything returns to IDLE immediately. The first edge after rst rises starts clean, with no phase violation for a transfer already in progress.

Decomposition:
- Package matmul_apb_mon_pkg: state enum (IDLE, SETUP, ACCESS), violation index constants VIOL_PHASE..VIOL_ERR_READY, NUM_VIOL = 6.
- Sub-module matmul_sat_counter (parametrised width, inc, clr, saturating), instantiated three times.

Test Plan:
- Legal write to 0x0004 (setup, 1 wait state, pready) then legal read -> wr_cnt=1, rd_cnt=1, viol=0, viol_pulse never high.
- psel & penable both rise from IDLE -> viol[0]=1, one viol_pulse; the transfer then completes, wr_cnt or rd_cnt = 1.
- paddr changes 0x0004->0x0008 during a wait state -> viol[1]=1. TIMEOUT_CYCLES=4 with no pready for 6 cycles -> viol[2]=1 after the 4th ACCESS cycle.
- Write pwdata=1 to paddr 0 completes with busy held low -> viol[4]=1. Repeat with busy high next cycle -> viol[4] stays 0.
- pready high 2 cycles -> viol[3]. pslverr & pready together -> viol[5] and err_cnt=1. Assert clr in the same cycle as a new completion -> counter reads 1.
- CNT_WIDTH=4, 17 writes -> wr_cnt=15, no wrap. Drop rst mid-ACCESS -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/matmul_apb_mon_pkg.sv
// Shared constants for the matmul APB protocol monitor.
package matmul_apb_mon_pkg;

  // Violation flag positions in the sticky viol vector
  localparam int NUM_VIOL       = 6;
  localparam int VIOL_PHASE     = 0;
  localparam int VIOL_UNSTABLE  = 1;
  localparam int VIOL_TIMEOUT   = 2;
  localparam int VIOL_PREADY_ST = 3;
  localparam int VIOL_BUSY_MISS = 4;
  localparam int VIOL_ERR_READY = 5;

  // Transfer phase FSM encoding (also driven out on the debug state port)
  typedef logic [1:0] mon_state_t;
  localparam mon_state_t ST_IDLE   = 2'd0;
  localparam mon_state_t ST_SETUP  = 2'd1;
  localparam mon_state_t ST_ACCESS = 2'd2;

  // Event counter slots
  localparam int CNT_WR  = 0;
  localparam int CNT_RD  = 1;
  localparam int CNT_ERR = 2;
  localparam int NUM_CNT = 3;

endpackage

// File: rtl/matmul_sat_counter.sv
// Saturating event counter with synchronous clear.
module matmul_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear restarts from this cycle's event so a coincident increment is kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (clr)             cnt <= inc ? W'(1) : '0;
    else if (inc && !(&cnt))  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/matmul_apb_monitor.sv
// Passive APB protocol monitor for the matmul accelerator slave port.
module matmul_apb_monitor
  import matmul_apb_mon_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int BUS_WIDTH      = 64,
  parameter int ADDR_WIDTH     = 16,
  parameter int SP_NTARGETS    = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [BUS_WIDTH-1:0]  pwdata,
  input  logic [BUS_WIDTH-1:0]  prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic                  busy,
  input  logic                  clr,
  output logic [NUM_VIOL-1:0]   viol,
  output logic                  viol_pulse,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [1:0]            state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  mon_state_t             st_q, st_d;
  logic                   capture, phase_err, done, armed;
  logic [ADDR_WIDTH-1:0]  cap_addr;
  logic                   cap_write;
  logic [BUS_WIDTH-1:0]   cap_wdata;
  logic [TW-1:0]          tcnt;
  logic                   to_hit, unstable, stuck, busy_miss, err_ready;
  logic                   prev_pready, bm_pend;
  logic [NUM_VIOL-1:0]    det;
  logic [NUM_CNT-1:0]     cnt_inc;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_q;

  // Read data and the pass-through sizing parameters carry no checks
  logic unused_sink;
  assign unused_sink = ^{prdata, DATA_WIDTH[0], SP_NTARGETS[0]};

  assign done = (st_q == ST_ACCESS) && (pready || pslverr);

  // Next phase, capture strobe and phase-sequence violations
  always_comb begin
    st_d      = st_q;
    capture   = 1'b0;
    phase_err = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          st_d    = ST_SETUP;
          capture = 1'b1;
        end else if (psel && penable) begin
          // Skipped SETUP; right after reset this is a transfer already in flight
          st_d      = ST_ACCESS;
          capture   = 1'b1;
          phase_err = armed;
        end
      end
      ST_SETUP: begin
        if (psel && penable) st_d = ST_ACCESS;
        else begin
          st_d      = ST_IDLE;
          phase_err = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (done) begin
          if (psel && !penable) begin
            st_d    = ST_SETUP;
            capture = 1'b1;
          end else begin
            st_d = ST_IDLE;
          end
        end else if (!psel) begin
          st_d      = ST_IDLE;
          phase_err = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Phase register; armed masks the phase check on the first edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      st_q  <= st_d;
      armed <= 1'b1;
    end
  end

  // Transfer attributes latched at the start of each tracked transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
    end else if (capture) begin
      cap_addr  <= paddr;
      cap_write <= pwrite;
      cap_wdata <= pwdata;
    end
  end

  assign to_hit = (st_q == ST_ACCESS) && !done && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter; saturates at the limit so a transfer flags once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                tcnt <= '0;
    else if (st_d != ST_ACCESS)              tcnt <= '0;
    else if ((st_q == ST_ACCESS) && !done &&
             (tcnt != TW'(TIMEOUT_CYCLES)))  tcnt <= tcnt + TW'(1);
  end

  // One-cycle history: previous pready and a pending start-command completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pready <= 1'b0;
      bm_pend     <= 1'b0;
    end else begin
      prev_pready <= pready;
      bm_pend     <= done && cap_write && (cap_addr == '0) && cap_wdata[0] && !pslverr;
    end
  end

  assign unstable  = (st_q == ST_ACCESS) && psel && penable &&
                     ((paddr != cap_addr) || (pwrite != cap_write) ||
                      (cap_write && (pwdata != cap_wdata)));
  assign stuck     = pready && prev_pready;
  assign busy_miss = bm_pend && !busy;
  assign err_ready = pready && pslverr;

  // Gather this cycle's violations into flag positions
  always_comb begin
    det                 = '0;
    det[VIOL_PHASE]     = phase_err;
    det[VIOL_UNSTABLE]  = unstable;
    det[VIOL_TIMEOUT]   = to_hit;
    det[VIOL_PREADY_ST] = stuck;
    det[VIOL_BUSY_MISS] = busy_miss;
    det[VIOL_ERR_READY] = err_ready;
  end

  // Sticky flags and the any-violation pulse; clr never hides a fresh hit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      viol       <= '0;
      viol_pulse <= 1'b0;
    end else begin
      viol       <= (clr ? '0 : viol) | det;
      viol_pulse <= |det;
    end
  end

  assign cnt_inc[CNT_WR]  = done && cap_write;
  assign cnt_inc[CNT_RD]  = done && !cap_write;
  assign cnt_inc[CNT_ERR] = done && pslverr;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    matmul_sat_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (cnt_inc[i]),
      .clr (clr),
      .cnt (cnt_q[i])
    );
  end

  assign wr_cnt  = cnt_q[CNT_WR];
  assign rd_cnt  = cnt_q[CNT_RD];
  assign err_cnt = cnt_q[CNT_ERR];
  assign state   = st_q;

endmodule

// File: tb/tb_matmul_apb_monitor.sv
// Directed vector bench for the matmul APB monitor.
module tb_matmul_apb_monitor;

  localparam int AW = 16;
  localparam int BW = 64;
  localparam int CW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [BW-1:0] pwdata = '0, prdata = '0;
  logic          pready = 1'b0, pslverr = 1'b0, busy = 1'b0, clr = 1'b0;
  logic [5:0]    viol;
  logic          viol_pulse;
  logic [CW-1:0] wr_cnt, rd_cnt, err_cnt;
  logic [1:0]    state;

  matmul_apb_monitor #(
    .DATA_WIDTH(16), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .SP_NTARGETS(4),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .busy(busy), .clr(clr), .viol(viol),
    .viol_pulse(viol_pulse), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
    .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          s, e, w;
    logic [AW-1:0] a;
    logic [BW-1:0] d;
    logic          rdy, err, bsy, cl;
    logic [5:0]    ev;
    logic          ep;
    int            ewr, erd, eer;
    logic [1:0]    est;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(input logic s, e, w, input logic [AW-1:0] a,
                             input logic [BW-1:0] d, input logic rdy, err, bsy, cl,
                             input logic [5:0] ev, input logic ep,
                             input int ewr, erd, eer, input logic [1:0] est);
    vec_t x;
    x.s = s; x.e = e; x.w = w; x.a = a; x.d = d;
    x.rdy = rdy; x.err = err; x.bsy = bsy; x.cl = cl;
    x.ev = ev; x.ep = ep; x.ewr = ewr; x.erd = erd; x.eer = eer; x.est = est;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, e, w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                       input logic rdy, err, bsy, cl);
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
    pready = rdy; pslverr = err; busy = bsy; clr = cl;
  endtask

  task automatic check_all(input string nm, input int idx, input logic [5:0] ev, input logic ep,
                           input int ewr, erd, eer, input logic [1:0] est);
    chk({nm, ".viol"},  idx, 64'(viol), 64'(ev));
    chk({nm, ".pulse"}, idx, 64'(viol_pulse), 64'(ep));
    chk({nm, ".wr"},    idx, 64'(wr_cnt), 64'(ewr));
    chk({nm, ".rd"},    idx, 64'(rd_cnt), 64'(erd));
    chk({nm, ".err"},   idx, 64'(err_cnt), 64'(eer));
    chk({nm, ".state"}, idx, 64'(state), 64'(est));
  endtask

  // Legal transfer: setup, access, access with pready, then idle
  task automatic do_xfer(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
    drive(1, 0, w, a, d, 0, 0, 0, 0); tick;
    drive(1, 1, w, a, d, 0, 0, 0, 0); tick;
    drive(1, 1, w, a, d, 1, 0, 0, 0); tick;
    drive(0, 0, 0, '0, '0, 0, 0, 0, 0); tick;
  endtask

  initial begin
    // legal write to 0x4 with a wait cycle, then legal read
    tbl.push_back(v(1,0,1,16'h4,64'hAA,0,0,0,0, 6'd0,0, 0,0,0, 2'd1));
    tbl.push_back(v(1,1,1,16'h4,64'hAA,0,0,0,0, 6'd0,0, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,1,16'h4,64'hAA,0,0,0,0, 6'd0,0, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,1,16'h4,64'hAA,1,0,0,0, 6'd0,0, 1,0,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0, 0,0,0,0, 6'd0,0, 1,0,0, 2'd0));
    tbl.push_back(v(1,0,0,16'h4,64'h0, 0,0,0,0, 6'd0,0, 1,0,0, 2'd1));
    tbl.push_back(v(1,1,0,16'h4,64'h0, 0,0,0,0, 6'd0,0, 1,0,0, 2'd2));
    tbl.push_back(v(1,1,0,16'h4,64'h0, 1,0,0,0, 6'd0,0, 1,1,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0, 0,0,0,0, 6'd0,0, 1,1,0, 2'd0));
    // psel and penable rise together from IDLE
    tbl.push_back(v(0,0,0,16'h0,64'h0, 0,0,0,1, 6'd0,0, 0,0,0, 2'd0));
    tbl.push_back(v(1,1,1,16'h8,64'h5, 0,0,0,0, 6'd1,1, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,1,16'h8,64'h5, 1,0,0,0, 6'd1,0, 1,0,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0, 0,0,0,0, 6'd1,0, 1,0,0, 2'd0));
    // paddr moves 0x4 -> 0x8 during the wait cycle
    tbl.push_back(v(0,0,0,16'h0,64'h0, 0,0,0,1, 6'd0,0, 0,0,0, 2'd0));
    tbl.push_back(v(1,0,1,16'h4,64'h1, 0,0,0,0, 6'd0,0, 0,0,0, 2'd1));
    tbl.push_back(v(1,1,1,16'h4,64'h1, 0,0,0,0, 6'd0,0, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,1,16'h8,64'h1, 0,0,0,0, 6'd2,1, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,1,16'h8,64'h1, 1,0,0,0, 6'd2,1, 1,0,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0, 0,0,0,0, 6'd2,0, 1,0,0, 2'd0));
    // read held 6 ACCESS cycles without pready, limit 4
    tbl.push_back(v(0,0,0,16'h0, 64'h0,0,0,0,1, 6'd0,0, 0,0,0, 2'd0));
    tbl.push_back(v(1,0,0,16'h10,64'h0,0,0,0,0, 6'd0,0, 0,0,0, 2'd1));
    tbl.push_back(v(1,1,0,16'h10,64'h0,0,0,0,0, 6'd0,0, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,0,16'h10,64'h0,0,0,0,0, 6'd0,0, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,0,16'h10,64'h0,0,0,0,0, 6'd0,0, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,0,16'h10,64'h0,0,0,0,0, 6'd0,0, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,0,16'h10,64'h0,0,0,0,0, 6'd4,1, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,0,16'h10,64'h0,0,0,0,0, 6'd4,0, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,0,16'h10,64'h0,1,0,0,0, 6'd4,0, 0,1,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0, 64'h0,0,0,0,0, 6'd4,0, 0,1,0, 2'd0));
    // start command to addr 0, busy stays low -> flag
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,0,1, 6'd0,0,  0,0,0, 2'd0));
    tbl.push_back(v(1,0,1,16'h0,64'h1,0,0,0,0, 6'd0,0,  0,0,0, 2'd1));
    tbl.push_back(v(1,1,1,16'h0,64'h1,0,0,0,0, 6'd0,0,  0,0,0, 2'd2));
    tbl.push_back(v(1,1,1,16'h0,64'h1,1,0,0,0, 6'd0,0,  1,0,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,0,0, 6'd16,1, 1,0,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,0,0, 6'd16,0, 1,0,0, 2'd0));
    // same command, busy high the cycle after -> no flag
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,0,1, 6'd0,0, 0,0,0, 2'd0));
    tbl.push_back(v(1,0,1,16'h0,64'h1,0,0,0,0, 6'd0,0, 0,0,0, 2'd1));
    tbl.push_back(v(1,1,1,16'h0,64'h1,0,0,0,0, 6'd0,0, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,1,16'h0,64'h1,1,0,0,0, 6'd0,0, 1,0,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,1,0, 6'd0,0, 1,0,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,0,0, 6'd0,0, 1,0,0, 2'd0));
    // pready held a second cycle after completion
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,0,1, 6'd0,0, 0,0,0, 2'd0));
    tbl.push_back(v(1,0,0,16'h4,64'h0,0,0,0,0, 6'd0,0, 0,0,0, 2'd1));
    tbl.push_back(v(1,1,0,16'h4,64'h0,0,0,0,0, 6'd0,0, 0,0,0, 2'd2));
    tbl.push_back(v(1,1,0,16'h4,64'h0,1,0,0,0, 6'd0,0, 0,1,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0,1,0,0,0, 6'd8,1, 0,1,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,0,0, 6'd8,0, 0,1,0, 2'd0));
    // pslverr together with pready
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,0,1, 6'd0,0,  0,0,0, 2'd0));
    tbl.push_back(v(1,0,0,16'h4,64'h0,0,0,0,0, 6'd0,0,  0,0,0, 2'd1));
    tbl.push_back(v(1,1,0,16'h4,64'h0,0,0,0,0, 6'd0,0,  0,0,0, 2'd2));
    tbl.push_back(v(1,1,0,16'h4,64'h0,1,1,0,0, 6'd32,1, 0,1,1, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,0,0, 6'd32,0, 0,1,1, 2'd0));
    // clr coinciding with a completion, then with violations
    tbl.push_back(v(1,0,0,16'h4,64'h0,0,0,0,0, 6'd32,0, 0,1,1, 2'd1));
    tbl.push_back(v(1,1,0,16'h4,64'h0,0,0,0,0, 6'd32,0, 0,1,1, 2'd2));
    tbl.push_back(v(1,1,0,16'h4,64'h0,1,0,0,1, 6'd0,0,  0,1,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0,1,1,0,1, 6'd40,1, 0,0,0, 2'd0));
    tbl.push_back(v(0,0,0,16'h0,64'h0,0,0,0,0, 6'd40,0, 0,0,0, 2'd0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 6'd0, 0, 0, 0, 0, 2'd0);
    rst = 1'b1;
    tick;

    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].d,
            tbl[i].rdy, tbl[i].err, tbl[i].bsy, tbl[i].cl);
      tick;
      check_all("vec", i, tbl[i].ev, tbl[i].ep, tbl[i].ewr, tbl[i].erd, tbl[i].eer, tbl[i].est);
    end

    // write counter saturates at 15 with 4-bit counters
    drive(0, 0, 0, '0, '0, 0, 0, 0, 1); tick;
    drive(0, 0, 0, '0, '0, 0, 0, 0, 0);
    for (int n = 0; n < 15; n++) do_xfer(1'b1, 16'h4, 64'h1);
    chk("sat.wr15", 0, 64'(wr_cnt), 64'd15);
    for (int n = 0; n < 2; n++) do_xfer(1'b1, 16'h4, 64'h1);
    chk("sat.wr17", 0, 64'(wr_cnt), 64'd15);
    chk("sat.rd",   0, 64'(rd_cnt), 64'd0);
    chk("sat.viol", 0, 64'(viol),   64'd0);

    // reset dropped mid-ACCESS, released with the transfer still on the bus
    drive(1, 1, 1, 16'h4, 64'h1, 0, 0, 0, 0); tick;
    check_all("pre_rst", 0, 6'd1, 1, 15, 0, 0, 2'd2);
    #2 rst = 1'b0;
    #1 check_all("in_rst", 0, 6'd0, 0, 0, 0, 0, 2'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst", 0, 6'd0, 0, 0, 0, 0, 2'd2);
    pready = 1'b1; tick;
    check_all("post_done", 0, 6'd0, 0, 1, 0, 0, 2'd0);
    drive(0, 0, 0, '0, '0, 0, 0, 0, 0); tick;
    check_all("post_idle", 0, 6'd0, 0, 1, 0, 0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
